// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//   End-of-test monitor for the riscv core. It watches the register-file
//   write-back port and keeps shadow copies of the done, pass and test-number
//   registers. It also watches the fetch PC to spot a stalled core, and it
//   reports a PASS/FAIL/TIMEOUT/HANG verdict with a cycle count.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               pulse; arms the monitor from IDLE or any terminal state
//   i_rd_we/addr/wdata    register-file write-back port (snooped)
//   i_pc                  current fetch PC
//   o_busy                RUN or SETTLE
//   o_done                any terminal state
//   o_pass/o_fail         PASS / FAIL verdict
//   o_timeout/o_hang      TIMEOUT / HANG verdict
//   o_fail_testnum        test number captured on entry to FAIL/TIMEOUT/HANG
//   o_cycle_count         cycles spent in RUN+SETTLE; frozen once terminal
module riscv_test_monitor #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TNUM_REG       = 3,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int HANG_CYCLES    = 64,
  parameter int CNT_W          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_rd_we,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [CPU_WIDTH-1:0]  i_rd_wdata,
  input  logic [CPU_WIDTH-1:0]  i_pc,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic                  o_timeout,
  output logic                  o_hang,
  output logic [CPU_WIDTH-1:0]  o_fail_testnum,
  output logic [CNT_W-1:0]      o_cycle_count
);

  localparam int HCNT_W = $clog2(HANG_CYCLES);
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SETTLE, S_PASS, S_FAIL, S_TIMEOUT, S_HANG
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CPU_WIDTH-1:0]  r_done_sh, r_pass_sh, r_tnum_sh;
  logic [CPU_WIDTH-1:0]  r_last_pc;
  logic [CPU_WIDTH-1:0]  r_fail_testnum;
  logic [CNT_W-1:0]      r_cycle_count;
  logic [HCNT_W-1:0]     r_hang_cnt;
  logic [SCNT_W-1:0]     r_settle_cnt;
  logic                  r_busy, r_done, r_pass, r_fail, r_timeout, r_hang;

  logic                  w_wr, w_wr_done, w_wr_pass, w_wr_tnum;
  logic                  w_terminal, w_accept;
  logic                  w_done_cond, w_timeout_hit, w_hang_hit, w_pc_same;
  logic [CPU_WIDTH-1:0]  w_pass_val, w_tnum_val;
  logic                  w_enter_bad;

  // Writes to x0 never reach a shadow.
  assign w_wr      = i_rd_we && (i_rd_addr != '0);
  assign w_wr_done = w_wr && (i_rd_addr == REG_ADDR_W'(DONE_REG));
  assign w_wr_pass = w_wr && (i_rd_addr == REG_ADDR_W'(PASS_REG));
  assign w_wr_tnum = w_wr && (i_rd_addr == REG_ADDR_W'(TNUM_REG));

  assign w_terminal = (r_state == S_PASS) || (r_state == S_FAIL) ||
                      (r_state == S_TIMEOUT) || (r_state == S_HANG);
  assign w_accept   = i_start && (w_terminal || (r_state == S_IDLE));

  // A write arriving this cycle counts as already visible. This lets the
  // verdict use a value that the shadow will only capture at this edge.
  assign w_done_cond   = (r_done_sh == CPU_WIDTH'(1)) ||
                         (w_wr_done && (i_rd_wdata == CPU_WIDTH'(1)));
  assign w_pass_val    = w_wr_pass ? i_rd_wdata : r_pass_sh;
  assign w_tnum_val    = w_wr_tnum ? i_rd_wdata : r_tnum_sh;
  assign w_timeout_hit = (r_cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_hang_hit    = (r_hang_cnt == HCNT_W'(HANG_CYCLES - 1));
  assign w_pc_same     = (i_pc == r_last_pc);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        // When conditions coincide, done wins over timeout, and timeout wins over hang.
        if (w_done_cond)        w_next = S_SETTLE;
        else if (w_timeout_hit) w_next = S_TIMEOUT;
        else if (w_hang_hit)    w_next = S_HANG;
      end
      S_SETTLE: begin
        if (r_settle_cnt == '0)
          w_next = (w_pass_val == CPU_WIDTH'(1)) ? S_PASS : S_FAIL;
      end
      default: begin
        if (w_accept) w_next = S_RUN;
      end
    endcase
  end

  assign w_enter_bad = ((r_state == S_RUN) || (r_state == S_SETTLE)) &&
                       ((w_next == S_FAIL) || (w_next == S_TIMEOUT) || (w_next == S_HANG));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_done_sh      <= '0;
      r_pass_sh      <= '0;
      r_tnum_sh      <= '0;
      r_last_pc      <= '0;
      r_fail_testnum <= '0;
      r_cycle_count  <= '0;
      r_hang_cnt     <= '0;
      r_settle_cnt   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_timeout      <= 1'b0;
      r_hang         <= 1'b0;
    end else begin
      r_state <= w_next;

      // The outputs decode the next state, so the flags and the state change together.
      r_busy    <= (w_next == S_RUN) || (w_next == S_SETTLE);
      r_done    <= (w_next == S_PASS) || (w_next == S_FAIL) ||
                   (w_next == S_TIMEOUT) || (w_next == S_HANG);
      r_pass    <= (w_next == S_PASS);
      r_fail    <= (w_next == S_FAIL);
      r_timeout <= (w_next == S_TIMEOUT);
      r_hang    <= (w_next == S_HANG);

      if (w_accept) begin
        r_done_sh      <= '0;
        r_pass_sh      <= '0;
        r_tnum_sh      <= '0;
        r_fail_testnum <= '0;
        r_cycle_count  <= '0;
        r_hang_cnt     <= '0;
        r_last_pc      <= i_pc;
      end else begin
        // Shadows stay frozen in terminal states so the end-of-test values remain visible.
        if (!w_terminal) begin
          if (w_wr_done) r_done_sh <= i_rd_wdata;
          if (w_wr_pass) r_pass_sh <= i_rd_wdata;
          if (w_wr_tnum) r_tnum_sh <= i_rd_wdata;
        end

        if ((r_state == S_RUN) || (r_state == S_SETTLE)) begin
          if (r_cycle_count != {CNT_W{1'b1}})
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end

        if (r_state == S_RUN) begin
          if (w_pc_same) begin
            if (!w_hang_hit) r_hang_cnt <= r_hang_cnt + HCNT_W'(1);
          end else begin
            r_hang_cnt <= '0;
            r_last_pc  <= i_pc;
          end
          if (w_done_cond) r_settle_cnt <= SCNT_W'(SETTLE_CYCLES - 1);
        end

        if ((r_state == S_SETTLE) && (r_settle_cnt != '0))
          r_settle_cnt <= r_settle_cnt - SCNT_W'(1);

        if (w_enter_bad) r_fail_testnum <= w_tnum_val;
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_timeout      = r_timeout;
  assign o_hang         = r_hang;
  assign o_fail_testnum = r_fail_testnum;
  assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor. Each test is a per-cycle trace of
// write-back and PC activity. A reference model works out the verdict from
// the trace and the monitor rules, and the result goes into a scoreboard.
// A separate monitor process compares the result whenever o_done rises.
module tb_riscv_test_monitor;
  localparam int W = 32, AW = 5, CW = 32;
  localparam int TO = 100, HC = 8, ST = 3;
  localparam int MAXL = 128;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, rd_we = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_wdata = '0, pc = '0;
  logic          o_busy, o_done, o_pass, o_fail, o_timeout, o_hang;
  logic [W-1:0]  o_fail_testnum;
  logic [CW-1:0] o_cycle_count;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .CPU_WIDTH(W), .REG_ADDR_W(AW), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(3),
    .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO), .HANG_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rd_we(rd_we),
    .i_rd_addr(rd_addr), .i_rd_wdata(rd_wdata), .i_pc(pc),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail),
    .o_timeout(o_timeout), .o_hang(o_hang), .o_fail_testnum(o_fail_testnum),
    .o_cycle_count(o_cycle_count)
  );

  // Trace: tr_*[t] is driven during cycle t of the run (cycle 0 follows start).
  logic          tr_we[MAXL];
  logic [AW-1:0] tr_addr[MAXL];
  logic [W-1:0]  tr_data[MAXL];
  logic [W-1:0]  tr_pc[MAXL];
  logic          tr_start[MAXL];
  logic [W-1:0]  tr_pc0;

  typedef struct {
    int       kind;  // 0 pass, 1 fail, 2 timeout, 3 hang
    int       cnt;
    logic [W-1:0] tnum;
    int       end_t;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Holds 1 if a real write to register r with value v happened in cycle t.
  function automatic bit wrote(input int r, input int t, input logic [W-1:0] v);
    return (t >= 0) && tr_we[t] && (tr_addr[t] == AW'(r)) && (r != 0) && (tr_data[t] == v);
  endfunction

  // Gives the value of architectural register r once cycle t's write has landed.
  function automatic logic [W-1:0] last_val(input int r, input int t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i <= t && i < MAXL; i++)
      if (tr_we[i] && tr_addr[i] == AW'(r) && r != 0) v = tr_data[i];
    return v;
  endfunction

  function automatic bit same_as_prev(input int i);
    logic [W-1:0] prev;
    prev = (i == 0) ? tr_pc0 : tr_pc[i-1];
    return tr_pc[i] == prev;
  endfunction

  // Hang in cycle t: each of the previous HC-1 cycles repeated the PC before it.
  function automatic bit hung(input int t);
    if (t < HC - 1) return 1'b0;
    for (int j = 1; j <= HC - 1; j++)
      if (!same_as_prev(t - j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.kind = 2; e.cnt = TO; e.tnum = '0; e.end_t = TO - 1;
    for (int t = 0; t < MAXL - ST; t++) begin
      if (last_val(26, t - 1) == 1 || wrote(26, t, 1)) begin
        e.end_t = t + ST;
        e.cnt   = t + ST + 1;
        e.kind  = (last_val(27, t + ST) == 1) ? 0 : 1;
        e.tnum  = (e.kind == 0) ? '0 : last_val(3, t + ST);
        return e;
      end
      if (t == TO - 1 || hung(t)) begin
        e.kind  = (t == TO - 1) ? 2 : 3;
        e.end_t = t;
        e.cnt   = t + 1;
        e.tnum  = last_val(3, t);
        return e;
      end
    end
    return e;
  endfunction

  task automatic clear_trace(input logic [W-1:0] base);
    tr_pc0 = base;
    for (int i = 0; i < MAXL; i++) begin
      tr_we[i] = 1'b0; tr_addr[i] = '0; tr_data[i] = '0; tr_start[i] = 1'b0;
      tr_pc[i] = base + W'(4 * (i + 1));
    end
  endtask

  task automatic set_wr(input int t, input int a, input logic [W-1:0] d);
    tr_we[t] = 1'b1; tr_addr[t] = AW'(a); tr_data[t] = d;
  endtask

  task automatic gen_random();
    int mode, hold_from, r;
    logic [W-1:0] p;
    mode = $urandom_range(0, 3);
    tr_pc0 = $urandom;
    p = tr_pc0;
    hold_from = (mode == 1) ? $urandom_range(0, 60) : MAXL;
    for (int i = 0; i < MAXL; i++) begin
      if (i < hold_from && $urandom_range(0, 9) != 0) p = p + 4;
      tr_pc[i]    = p;
      tr_start[i] = ($urandom_range(0, 19) == 0);
      tr_we[i]    = ($urandom_range(0, 99) < 35);
      r = $urandom_range(0, 9);
      case (r)
        0:       tr_addr[i] = '0;
        1, 2:    tr_addr[i] = AW'(3);
        3, 4:    tr_addr[i] = AW'(27);
        5, 6:    tr_addr[i] = AW'(26);
        default: tr_addr[i] = AW'($urandom_range(0, 31));
      endcase
      if (tr_addr[i] == AW'(27))
        tr_data[i] = W'($urandom_range(0, 1));
      else if (tr_addr[i] == AW'(26))
        tr_data[i] = (mode >= 2 && $urandom_range(0, 3) == 0) ? W'(1) :
                     (($urandom_range(0, 1) == 0) ? W'(0) : W'($urandom_range(2, 9)));
      else
        tr_data[i] = W'($urandom_range(0, 15));
      // Disabled writes may still carry the done pattern; they must not count.
      if (!tr_we[i] && $urandom_range(0, 4) == 0) begin
        tr_addr[i] = AW'(26); tr_data[i] = W'(1);
      end
    end
  endtask

  task automatic run_test();
    exp_t e;
    e = model();
    sbq.push_back(e);
    start = 1'b1; rd_we = 1'b0; pc = tr_pc0;
    @(posedge clk); #1;
    for (int t = 0; t <= e.end_t; t++) begin
      start = tr_start[t]; rd_we = tr_we[t]; rd_addr = tr_addr[t];
      rd_wdata = tr_data[t]; pc = tr_pc[t];
      @(posedge clk); #1;
    end
    // Terminal state: writes (including the test number) must not disturb the verdict.
    for (int k = 0; k < 4; k++) begin
      start = 1'b0; rd_we = 1'b1;
      rd_addr = (k % 2 == 0) ? AW'(3) : AW'(26 + k / 2);
      rd_wdata = W'($urandom_range(1, 99)); pc = $urandom;
      @(posedge clk); #1;
    end
    rd_we = 1'b0;
    if (sbq.size() != 0) begin
      vectors++; errors++;
      $display("FAIL no_verdict: got done=%0b expected a verdict by cycle %0d", o_done, e.end_t);
      sbq.delete();
    end else begin
      chk("hold_done", {63'd0, o_done}, 64'd1);
      chk("hold_testnum", {32'd0, o_fail_testnum}, {32'd0, e.tnum});
      chk("hold_count", {32'd0, o_cycle_count}, 64'(e.cnt));
    end
  endtask

  // Scoreboard monitor: one verdict per rising edge of o_done.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ef;
    if (rst_n && o_done && !done_q) begin
      if (sbq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_verdict: got flags %b expected none", {o_hang, o_timeout, o_fail, o_pass});
      end else begin
        e  = sbq.pop_front();
        ef = 4'(1 << e.kind);
        chk("verdict_flags", {60'd0, o_hang, o_timeout, o_fail, o_pass}, {60'd0, ef});
        chk("busy_off", {63'd0, o_busy}, 64'd0);
        chk("cycle_count", {32'd0, o_cycle_count}, 64'(e.cnt));
        chk("fail_testnum", {32'd0, o_fail_testnum}, {32'd0, e.tnum});
      end
    end
    done_q = o_done;
  end

  initial begin
    #2;
    chk("reset_outputs", {o_busy, o_done, o_pass, o_fail, o_timeout, o_hang, 26'd0, o_fail_testnum} ^ 64'd0, 64'd0);
    chk("reset_count", {32'd0, o_cycle_count}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass: x27=1 at cycle 10 and x26=1 at cycle 20.
    clear_trace(32'h1000); set_wr(10, 27, 1); set_wr(20, 26, 1); run_test();
    // Second run after PASS: x27=0 gives FAIL with test number 5.
    clear_trace(32'h2000); set_wr(2, 3, 5); set_wr(4, 27, 0); set_wr(6, 26, 1); run_test();
    // Timeout with the PC always moving and x3=7.
    clear_trace(32'h3000); set_wr(10, 3, 7); run_test();
    // Hang with PC parked at 0x40 from cycle 5.
    clear_trace(32'h4000); set_wr(1, 3, 9);
    for (int i = 5; i < MAXL; i++) tr_pc[i] = 32'h40;
    run_test();
    // Same hang setup, but done arrives on the 8th equal-PC cycle.
    clear_trace(32'h4000);
    for (int i = 5; i < MAXL; i++) tr_pc[i] = 32'h40;
    set_wr(13, 26, 1); run_test();
    // Disabled write of the done pattern, an x0 write, and a start during RUN.
    clear_trace(32'h5000);
    tr_addr[3] = AW'(26); tr_data[3] = 1; set_wr(4, 0, 1); tr_start[5] = 1'b1;
    set_wr(8, 27, 1); set_wr(30, 26, 1); run_test();
    // x27=1 written in the second SETTLE cycle.
    clear_trace(32'h6000); set_wr(5, 27, 0); set_wr(10, 26, 1); set_wr(12, 27, 1); run_test();

    // Reset asserted in the middle of SETTLE.
    start = 1'b1; pc = 32'h7000; @(posedge clk); #1; start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      rd_we = (t == 2); rd_addr = AW'(26); rd_wdata = 1; pc = 32'h7004 + W'(4 * t);
      @(posedge clk); #1;
    end
    rd_we = 1'b0;
    chk("busy_settle", {63'd0, o_busy}, 64'd1);
    rst_n = 1'b0; #1;
    chk("midreset_flags", {58'd0, o_busy, o_done, o_pass, o_fail, o_timeout, o_hang}, 64'd0);
    chk("midreset_vals", {o_fail_testnum, o_cycle_count}, 64'd0);
    @(posedge clk); #1;
    chk("reset_hold", {63'd0, o_done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_test();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
